// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the architectural NZCV flags, resolves conditional branches
// against them (with same-cycle flag forwarding) and drives the PC redirect and pipeline flush.
module branch_cond_unit #(
  parameter int unsigned N            = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   flags_in,
  input  logic         flags_we,
  input  logic         br_valid,
  output logic         br_ready,
  input  logic [3:0]   br_cond,
  input  logic [N-1:0] br_target,
  output logic         br_taken,
  output logic [N-1:0] br_pc,
  output logic         flush,
  output logic [3:0]   flags_q
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_next;
  logic [3:0]   r_flags;
  logic         r_taken;
  logic [N-1:0] r_pc;

  logic [3:0]   w_flags_eff;
  logic         w_n, w_z, w_c, w_v;
  logic         w_cond_true;
  logic         w_accept;
  logic         w_take;

  // A flag write in the same cycle as the branch is seen by the branch.
  assign w_flags_eff = flags_we ? flags_in : r_flags;
  assign w_n = w_flags_eff[3];
  assign w_z = w_flags_eff[2];
  assign w_c = w_flags_eff[1];
  assign w_v = w_flags_eff[0];

  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      4'b0000: w_cond_true = 1'b1;
      4'b0001: w_cond_true = w_z;
      4'b0010: w_cond_true = ~w_z;
      4'b0011: w_cond_true = ~w_z & (w_n == w_v);
      4'b0100: w_cond_true = (w_n != w_v);
      4'b0101: w_cond_true = (w_n == w_v);
      4'b0110: w_cond_true = w_z | (w_n != w_v);
      4'b0111: w_cond_true = w_c;
      4'b1000: w_cond_true = w_v;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign br_ready = (r_state != StFlush);
  assign w_accept = br_valid & br_ready;
  assign w_take   = w_accept & w_cond_true;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_take) begin
          w_state_next = StFlush;
          w_cnt_next   = 4'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (r_cnt == 4'd0) begin
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Flag writes arriving during a flush come from squashed instructions and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= 4'b0000;
      r_taken <= 1'b0;
      r_pc    <= '0;
    end else begin
      if (flags_we && (r_state != StFlush)) begin
        r_flags <= flags_in;
      end
      r_taken <= w_take;
      if (w_take) begin
        r_pc <= br_target;
      end
    end
  end

  assign br_taken = r_taken;
  assign br_pc    = r_pc;
  assign flush    = (r_state == StFlush);
  assign flags_q  = r_flags;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit; a second instance with a one-cycle flush
// covers the shortest flush length.
module tb_branch_cond_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  flags_in;
  logic        flags_we;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [15:0] br_target;

  logic        br_ready, br_taken, flush;
  logic [15:0] br_pc;
  logic [3:0]  flags_q;

  logic        br_ready1, br_taken1, flush1;
  logic [15:0] br_pc1;
  logic [3:0]  flags_q1;

  int n_checks = 0;
  int n_errors = 0;

  branch_cond_unit #(.N(16), .FLUSH_CYCLES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flags_in  (flags_in),
    .flags_we  (flags_we),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .br_target (br_target),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .flush     (flush),
    .flags_q   (flags_q)
  );

  branch_cond_unit #(.N(16), .FLUSH_CYCLES(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .flags_in  (flags_in),
    .flags_we  (flags_we),
    .br_valid  (br_valid),
    .br_ready  (br_ready1),
    .br_cond   (br_cond),
    .br_target (br_target),
    .br_taken  (br_taken1),
    .br_pc     (br_pc1),
    .flush     (flush1),
    .flags_q   (flags_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flags_we  = 1'b0;
    flags_in  = 4'b0000;
    br_valid  = 1'b0;
    br_cond   = 4'b1111;
    br_target = 16'h0000;
  endtask

  task automatic branch(input logic [3:0] cond, input logic [15:0] tgt);
    br_valid  = 1'b1;
    br_cond   = cond;
    br_target = tgt;
  endtask

  task automatic write_flags(input logic [3:0] f);
    flags_we = 1'b1;
    flags_in = f;
    tick();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    tick();
    check("rst_flags", 16'(flags_q), 16'h0000);
    check("rst_ready", 16'(br_ready), 16'h0001);
    check("rst_flush", 16'(flush), 16'h0000);
    check("rst_taken", 16'(br_taken), 16'h0000);
    check("rst_pc", br_pc, 16'h0000);
    tick();
    rst = 1'b1;
    tick();

    // Forwarded EQ: Z written in the same cycle as the branch
    flags_we = 1'b1;
    flags_in = 4'b0100;
    branch(4'b0001, 16'h0040);
    tick();
    idle_inputs();
    check("eq_taken", 16'(br_taken), 16'h0001);
    check("eq_pc", br_pc, 16'h0040);
    check("eq_flush0", 16'(flush), 16'h0001);
    check("eq_ready0", 16'(br_ready), 16'h0000);
    check("eq_flags", 16'(flags_q), 16'h0004);
    tick();
    check("eq_taken_pulse", 16'(br_taken), 16'h0000);
    check("eq_flush1", 16'(flush), 16'h0001);
    check("eq_ready1", 16'(br_ready), 16'h0000);
    check("eq_pc_hold", br_pc, 16'h0040);
    tick();
    check("eq_flush_end", 16'(flush), 16'h0000);
    check("eq_ready_end", 16'(br_ready), 16'h0001);

    // Stored GT / LT
    write_flags(4'b0000);
    branch(4'b0011, 16'h0100);
    tick();
    idle_inputs();
    check("gt_taken", 16'(br_taken), 16'h0001);
    check("gt_pc", br_pc, 16'h0100);
    tick();
    tick();
    write_flags(4'b1000);
    branch(4'b0100, 16'h0200);
    tick();
    idle_inputs();
    check("lt_taken", 16'(br_taken), 16'h0001);
    check("lt_pc", br_pc, 16'h0200);
    tick();
    tick();
    branch(4'b0011, 16'h0300);
    tick();
    idle_inputs();
    check("gt_nt_taken", 16'(br_taken), 16'h0000);
    check("gt_nt_flush", 16'(flush), 16'h0000);
    check("gt_nt_pc_hold", br_pc, 16'h0200);

    // Flag write and branch request during flush are both dropped
    branch(4'b0000, 16'h0500);
    tick();
    check("sq_taken", 16'(br_taken), 16'h0001);
    flags_we = 1'b1;
    flags_in = 4'b0100;
    branch(4'b0000, 16'h0600);
    tick();
    idle_inputs();
    check("sq_flags", 16'(flags_q), 16'h0008);
    check("sq_no_taken", 16'(br_taken), 16'h0000);
    tick();
    check("sq_exit_taken", 16'(br_taken), 16'h0000);
    check("sq_exit_flush", 16'(flush), 16'h0000);
    check("sq_pc", br_pc, 16'h0500);

    // Back-to-back not-taken BNE with Z=1
    write_flags(4'b0100);
    for (int i = 0; i < 3; i++) begin
      branch(4'b0010, 16'h0700 + 16'(i));
      tick();
      check("bne_ready", 16'(br_ready), 16'h0001);
      check("bne_taken", 16'(br_taken), 16'h0000);
      check("bne_flush", 16'(flush), 16'h0000);
    end
    idle_inputs();

    // NEVER
    branch(4'b1111, 16'h0800);
    tick();
    idle_inputs();
    check("never_taken", 16'(br_taken), 16'h0000);
    check("never_flush", 16'(flush), 16'h0000);

    // Asynchronous reset in the middle of a flush
    branch(4'b0000, 16'h0900);
    tick();
    idle_inputs();
    check("mid_flush_pre", 16'(flush), 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    check("arst_flush", 16'(flush), 16'h0000);
    check("arst_flags", 16'(flags_q), 16'h0000);
    check("arst_ready", 16'(br_ready), 16'h0001);
    check("arst_taken", 16'(br_taken), 16'h0000);
    check("arst_pc", br_pc, 16'h0000);
    tick();
    rst = 1'b1;
    tick();

    // AL to FFFE on both the 2-cycle and 1-cycle flush instances
    branch(4'b0000, 16'hFFFE);
    tick();
    idle_inputs();
    check("al_taken", 16'(br_taken), 16'h0001);
    check("al_pc", br_pc, 16'hFFFE);
    check("al1_taken", 16'(br_taken1), 16'h0001);
    check("al1_pc", br_pc1, 16'hFFFE);
    check("al1_flush0", 16'(flush1), 16'h0001);
    check("al1_ready0", 16'(br_ready1), 16'h0000);
    tick();
    check("al1_flush_end", 16'(flush1), 16'h0000);
    check("al1_ready_end", 16'(br_ready1), 16'h0001);
    check("al1_taken_pulse", 16'(br_taken1), 16'h0000);
    check("al_flush1", 16'(flush), 16'h0001);
    tick();
    check("al_flush_end", 16'(flush), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
